// File: rtl/enc_mix_pkg.sv
// Shared types and level arithmetic for the encoder colour mixer.
// Optional fast-turn acceleration is enabled with `define ENC_MIX_ACCEL_EN.
package enc_mix_pkg;

  typedef enum logic [1:0] {STEP_NONE, STEP_UP, STEP_DN} step_e;

  localparam int ACCEL_STEP = 4;
  localparam int MAXW       = 16;

  // Returns {sat, new_level}. max_lvl must be 2**WIDTH-1, so it doubles as the wrap mask.
  function automatic logic [MAXW:0] sat_add(input logic [MAXW-1:0] level,
                                            input logic [MAXW-1:0] step,
                                            input logic [MAXW-1:0] max_lvl,
                                            input logic            up,
                                            input logic            wrap);
    logic [MAXW:0]   ext;
    logic            sat;
    logic [MAXW-1:0] nl;
    sat = 1'b0;
    nl  = level;
    if (up) ext = {1'b0, level} + {1'b0, step};
    else    ext = {1'b0, level} - {1'b0, step};
    if (wrap) begin
      nl = ext[MAXW-1:0] & max_lvl;
    end else if (up) begin
      if (level == max_lvl)              sat = 1'b1;
      else if (ext > {1'b0, max_lvl})    nl  = max_lvl;
      else                               nl  = ext[MAXW-1:0];
    end else begin
      if (level == '0)                   sat = 1'b1;
      else if (ext[MAXW])                nl  = '0;
      else                               nl  = ext[MAXW-1:0];
    end
    return {sat, nl};
  endfunction

endpackage

// File: rtl/enc_color_mixer_div.sv
// Detent divider: accumulates cw/ccw pulses and reports a step when a full detent completes.
// Unaffected by ENC_MIX_ACCEL_EN.
module enc_detent_div
  import enc_mix_pkg::*;
#(
  parameter int DETENT = 4
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  cw_i,
  input  logic  ccw_i,
  input  logic  clr_i,
  output step_e step_o
);

  localparam int                    AW  = $clog2(DETENT + 1) + 1;
  localparam logic signed [AW-1:0]  LIM = AW'(DETENT - 1);

  logic signed [AW-1:0] acc_q, acc_d;

  always_comb begin
    acc_d  = acc_q;
    step_o = STEP_NONE;
    if (cw_i && !ccw_i) begin
      if (acc_q == LIM) begin
        step_o = STEP_UP;
        acc_d  = '0;
      end else begin
        acc_d = acc_q + AW'(1);
      end
    end else if (ccw_i && !cw_i) begin
      if (acc_q == -LIM) begin
        step_o = STEP_DN;
        acc_d  = '0;
      end else begin
        acc_d = acc_q - AW'(1);
      end
    end
    // A completed detent still reports its step; only the partial count is dropped.
    if (clr_i) acc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end

endmodule

// File: rtl/enc_color_mixer.sv
// Encoder-driven N-channel brightness mixer: channel select, level registers, step/sat strobes.
// `define ENC_MIX_ACCEL_EN adds a fast-turn step of ACCEL_STEP within ACCEL_WIN cycles.
module enc_color_mixer
  import enc_mix_pkg::*;
#(
  parameter int NCH       = 3,
  parameter int WIDTH     = 4,
  parameter int DETENT    = 4,
  parameter int WRAP      = 0,
  parameter int ACCEL_WIN = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cw_i,
  input  logic                      ccw_i,
  input  logic                      sel_i,
  output logic [NCH*WIDTH-1:0]      level_o,
  output logic [$clog2(NCH)-1:0]    ch_sel_o,
  output logic                      step_pulse_o,
  output logic                      sat_o
);

  localparam int              CW      = $clog2(NCH);
  localparam logic [MAXW-1:0] MAX_LVL = MAXW'((1 << WIDTH) - 1);

  logic [WIDTH-1:0] level_q [NCH];
  logic [CW-1:0]    ch_sel_q;
  logic             step_pulse_q;
  logic             sat_q;
  step_e            step;
  logic [MAXW-1:0]  step_amt;
  logic [MAXW-1:0]  cur_lvl;
  logic [MAXW:0]    add_res;

  enc_detent_div #(.DETENT(DETENT)) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .cw_i    (cw_i),
    .ccw_i   (ccw_i),
    .clr_i   (sel_i),
    .step_o  (step)
  );

`ifdef ENC_MIX_ACCEL_EN
  localparam int TW = $clog2(ACCEL_WIN + 1);
  logic [TW-1:0] since_q;

  // Starts saturated so the first detent after reset is never accelerated.
  always_ff @(posedge clk) begin
    if (!reset_n)                          since_q <= TW'(ACCEL_WIN);
    else if (step != STEP_NONE || sel_i)   since_q <= '0;
    else if (since_q != TW'(ACCEL_WIN))    since_q <= since_q + 1'b1;
  end

  assign step_amt = (since_q < TW'(ACCEL_WIN)) ? MAXW'(ACCEL_STEP) : MAXW'(1);
`else
  assign step_amt = MAXW'(1);
`endif

  assign cur_lvl = MAXW'(level_q[ch_sel_q]);
  assign add_res = sat_add(cur_lvl, step_amt, MAX_LVL, step == STEP_UP, WRAP != 0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NCH; k++) level_q[k] <= '0;
      ch_sel_q     <= '0;
      step_pulse_q <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      step_pulse_q <= 1'b0;
      sat_q        <= 1'b0;
      if (step != STEP_NONE) begin
        if (add_res[MAXW]) begin
          sat_q <= 1'b1;
        end else begin
          step_pulse_q        <= 1'b1;
          level_q[ch_sel_q]   <= add_res[WIDTH-1:0];
        end
      end
      if (sel_i) ch_sel_q <= (ch_sel_q == CW'(NCH - 1)) ? '0 : ch_sel_q + 1'b1;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lvl
    assign level_o[k*WIDTH +: WIDTH] = level_q[k];
  end

  assign ch_sel_o     = ch_sel_q;
  assign step_pulse_o = step_pulse_q;
  assign sat_o        = sat_q;

endmodule
